// File: rtl/div_mon_pkg.sv
// -----------------------------------------------------------------------------
// div_mon_pkg
// Shared types and default constants for the divided-clock period monitor.
//   mon_state_t     : FSM state encoding (IDLE, ACQUIRE, LOCKED, LOST)
//   DEF_EXP_DIV     : default expected period in clk cycles
//   DEF_CNT_W       : default period counter / period output width
//   DEF_LOCK_CNT    : default consecutive matches required to lock
//   DEF_UNLOCK_CNT  : default consecutive mismatches that drop lock
// -----------------------------------------------------------------------------
package div_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } mon_state_t;

    localparam int unsigned DEF_EXP_DIV    = 3;
    localparam int unsigned DEF_CNT_W      = 8;
    localparam int unsigned DEF_LOCK_CNT   = 4;
    localparam int unsigned DEF_UNLOCK_CNT = 2;

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Rising-edge detector for a signal already synchronous to clk.
//   clk   : clock
//   reset : asynchronous active-low reset (clears the history register)
//   d     : sampled input
//   rise  : high in the cycle where d is 1 and was 0 on the previous cycle
// The history register resets to 0, so a d that is already high when reset
// releases counts as a rise on the first clock.
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic q_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev_q <= 1'b0;
        end else begin
            q_prev_q <= d;
        end
    end

    assign rise = d & ~q_prev_q;

endmodule

// File: rtl/div_period_monitor.sv
// -----------------------------------------------------------------------------
// div_period_monitor
// Measures the rise-to-rise period of a divided pulse train and tracks
// whether it settles on the expected division ratio.
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous active-low reset
//   q_in         : divided pulse train, synchronous to clk
//   period       : last measured rise-to-rise period in clk cycles
//   period_valid : one-cycle pulse when period updates
//   match        : one-cycle pulse with period_valid when period == EXP_DIV
//   locked       : high while the FSM is LOCKED
//   lost         : one-cycle pulse on LOCKED -> LOST
//   timeout      : one-cycle pulse when the period counter saturates
// Every output is a register; q_in only reaches outputs through flops.
// -----------------------------------------------------------------------------
module div_period_monitor
    import div_mon_pkg::*;
#(
    parameter int unsigned EXP_DIV    = DEF_EXP_DIV,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
    parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             match,
    output logic             locked,
    output logic             lost,
    output logic             timeout
);

    localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned EC_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_VAL     = CNT_W'(EXP_DIV);
    // Compare against "count - 1" so the increment and the threshold test
    // happen on the same rise.
    localparam logic [MC_W-1:0]  LOCK_LAST   = MC_W'(LOCK_CNT - 1);
    localparam logic [EC_W-1:0]  UNLOCK_LAST = EC_W'(UNLOCK_CNT - 1);

    logic             rise;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             is_match;
    logic             saturated;

    mon_state_t       state_q;
    logic [MC_W-1:0]  match_cnt_q;
    logic [EC_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             match_q;
    logic             locked_q;
    logic             lost_q;
    logic             timeout_q;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .rise  (rise)
    );

    // Period counter: a rise N cycles after the previous one sees cnt == N.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_match  = (cnt_q == EXP_VAL);
    assign saturated = (cnt_q == CNT_MAX);

    // Monitor FSM with registered outputs. A rise always takes priority over
    // saturation, so a period of exactly CNT_MAX is reported, not timed out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            match_cnt_q    <= '0;
            err_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            match_q        <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            match_q        <= 1'b0;
            lost_q         <= 1'b0;
            timeout_q      <= 1'b0;
            locked_q       <= (state_q == ST_LOCKED);

            if (state_q == ST_IDLE) begin
                // First edge only opens the measurement window.
                if (rise) begin
                    state_q     <= ST_ACQUIRE;
                    match_cnt_q <= '0;
                    err_cnt_q   <= '0;
                end
            end else if (rise) begin
                period_q       <= cnt_q;
                period_valid_q <= 1'b1;
                match_q        <= is_match;

                case (state_q)
                    ST_ACQUIRE: begin
                        if (!is_match) begin
                            match_cnt_q <= '0;
                        end else if (match_cnt_q == LOCK_LAST) begin
                            state_q     <= ST_LOCKED;
                            locked_q    <= 1'b1;
                            match_cnt_q <= '0;
                            err_cnt_q   <= '0;
                        end else begin
                            match_cnt_q <= match_cnt_q + MC_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (is_match) begin
                            err_cnt_q <= '0;
                        end else if (err_cnt_q == UNLOCK_LAST) begin
                            state_q   <= ST_LOST;
                            locked_q  <= 1'b0;
                            lost_q    <= 1'b1;
                            err_cnt_q <= '0;
                        end else begin
                            err_cnt_q <= err_cnt_q + EC_W'(1);
                        end
                    end
                    ST_LOST: begin
                        // The rise leaving LOST already counts toward relock.
                        if (is_match && (LOCK_CNT == 1)) begin
                            state_q     <= ST_LOCKED;
                            locked_q    <= 1'b1;
                            match_cnt_q <= '0;
                        end else begin
                            state_q     <= ST_ACQUIRE;
                            match_cnt_q <= is_match ? MC_W'(1) : '0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (saturated) begin
                // Leaving the tracking states here makes the pulse one-shot:
                // cnt keeps holding CNT_MAX in IDLE without re-triggering.
                state_q     <= ST_IDLE;
                timeout_q   <= 1'b1;
                locked_q    <= 1'b0;
                match_cnt_q <= '0;
                err_cnt_q   <= '0;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign match        = match_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_div_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_div_period_monitor
// Self-checking bench for div_period_monitor. The reference model tracks
// rise times as absolute cycle numbers and derives periods, lock and timeout
// from elapsed time and run lengths of matching / mismatching periods.
// -----------------------------------------------------------------------------
module tb_div_period_monitor;

    localparam int EXP     = 3;
    localparam int CW      = 8;
    localparam int LOCKN   = 4;
    localparam int UNLOCKN = 2;
    localparam int MAXV    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          q_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          match;
    logic          locked;
    logic          lost;
    logic          timeout;

    always #5 clk = ~clk;

    div_period_monitor #(
        .EXP_DIV    (EXP),
        .CNT_W      (CW),
        .LOCK_CNT   (LOCKN),
        .UNLOCK_CNT (UNLOCKN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .q_in         (q_in),
        .period       (period),
        .period_valid (period_valid),
        .match        (match),
        .locked       (locked),
        .lost         (lost),
        .timeout      (timeout)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int   now;        // absolute edge number
    bit   m_prev;     // q_in seen at the previous edge
    bit   m_track;    // a first edge has been seen since reset/timeout
    bit   m_locked;
    bit   m_relock;   // lock was just lost; next rise restarts acquisition
    int   m_last;     // edge number of the most recent rise
    int   m_good;     // run of matching periods while acquiring
    int   m_bad;      // run of mismatching periods while locked
    int   m_period;
    bit   e_pv, e_match, e_lost, e_to;

    logic [CW+4:0] exp_vec;
    logic [CW+4:0] obs_vec;
    assign obs_vec = {period, period_valid, match, locked, lost, timeout};

    logic stim[$];

    function automatic void model_reset();
        m_prev   = 1'b0;
        m_track  = 1'b0;
        m_locked = 1'b0;
        m_relock = 1'b0;
        m_last   = 0;
        m_good   = 0;
        m_bad    = 0;
        m_period = 0;
        exp_vec  = '0;
    endfunction

    function automatic void model_edge(input logic q);
        bit rise;
        int gap;
        rise   = q && !m_prev;
        m_prev = q;
        now++;
        e_pv = 0; e_match = 0; e_lost = 0; e_to = 0;
        if (!m_track) begin
            if (rise) begin
                m_track = 1; m_last = now; m_good = 0; m_bad = 0; m_relock = 0;
            end
        end else if (rise) begin
            gap = now - m_last;
            if (gap > MAXV) gap = MAXV;
            m_last   = now;
            m_period = gap;
            e_pv     = 1;
            e_match  = (gap == EXP);
            if (m_locked) begin
                if (e_match) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad == UNLOCKN) begin
                        m_locked = 0; e_lost = 1; m_bad = 0; m_relock = 1;
                    end
                end
            end else if (m_relock) begin
                m_relock = 0;
                m_good   = e_match ? 1 : 0;
            end else if (e_match) begin
                m_good++;
                if (m_good == LOCKN) begin
                    m_locked = 1; m_good = 0; m_bad = 0;
                end
            end else begin
                m_good = 0;
            end
        end else if (now - m_last >= MAXV) begin
            e_to = 1; m_track = 0; m_locked = 0; m_relock = 0;
        end
        exp_vec = {CW'(m_period), e_pv, e_match, m_locked, e_lost, e_to};
    endfunction

    // period rise-to-rise, q_in high for 'high' cycles, repeated 'reps' times
    function automatic void push_pattern(input int per, input int high, input int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < per; k++)
                stim.push_back(k < high);
    endfunction

    task automatic step(input logic q);
        @(negedge clk);
        q_in = q;
        @(posedge clk);
        model_edge(q);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        q_in  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec !== '0) $display("FAIL reset_outputs: got %h want 0", obs_vec);
        else n_pass++;
        q_in = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_vec !== '0) $display("FAIL reset_hold_q_high: got %h want 0", obs_vec);
        else n_pass++;
        @(posedge clk);
        #3;
        reset = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_lock();
        int lock_rise = 0;
        int good_valid = 0;
        stim = {};
        push_pattern(3, 1, 8);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL lock_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (locked && lock_rise == 0) lock_rise = i / 3 + 1;
            if (period_valid && match && period == CW'(3)) good_valid++;
        end
        n_checks++;
        if (lock_rise !== 5) $display("FAIL lock_rise_index: got %0d want 5", lock_rise);
        else n_pass++;
        n_checks++;
        if (good_valid !== 7) $display("FAIL lock_match_pulses: got %0d want 7", good_valid);
        else n_pass++;
        $display("test_lock done");
    endtask

    task automatic test_lose_lock();
        int lost_n = 0;
        int p4_n = 0;
        int p4_match = 0;
        stim = {};
        push_pattern(4, 1, 2);
        push_pattern(3, 1, 6);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL lose_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (lost) lost_n++;
            if (period_valid && period == CW'(4)) begin
                p4_n++;
                if (match) p4_match++;
            end
        end
        n_checks++;
        if (lost_n !== 1) $display("FAIL lose_lost_pulses: got %0d want 1", lost_n);
        else n_pass++;
        n_checks++;
        if (p4_n !== 2 || p4_match !== 0)
            $display("FAIL lose_period4: got %0d/%0d want 2/0 (count/matched)", p4_n, p4_match);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL lose_relocked: got %b want 1", locked);
        else n_pass++;
        $display("test_lose_lock done");
    endtask

    task automatic test_glitch();
        int unlocked_cycles = 0;
        stim = {};
        push_pattern(2, 1, 1);
        push_pattern(3, 1, 3);
        push_pattern(2, 1, 1);
        push_pattern(3, 1, 3);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL glitch_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (!locked) unlocked_cycles++;
        end
        // the second lone short period would unlock if the first had not been cleared
        n_checks++;
        if (unlocked_cycles !== 0) $display("FAIL glitch_stays_locked: got %0d unlocked cycles want 0", unlocked_cycles);
        else n_pass++;
        $display("test_glitch done");
    endtask

    task automatic test_timeout();
        int to_n = 0;
        int to_idx = -1;
        int pv_early = 0;
        int pv_total = 0;
        apply_reset();
        stim = {};
        push_pattern(3, 1, 2);          // IDLE edge at 0, acquire rise at 3
        for (int k = 0; k < 300; k++) stim.push_back(1'b0);
        push_pattern(3, 1, 3);          // starts at index 306
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL timeout_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (timeout) begin
                to_n++;
                if (to_idx < 0) to_idx = i;
            end
            if (i >= 306 && period_valid) begin
                pv_total++;
                if (i < 309) pv_early++;
            end
        end
        n_checks++;
        if (to_n !== 1) $display("FAIL timeout_pulses: got %0d want 1", to_n);
        else n_pass++;
        n_checks++;
        if (to_idx !== 3 + MAXV) $display("FAIL timeout_position: got %0d want %0d", to_idx, 3 + MAXV);
        else n_pass++;
        n_checks++;
        if (pv_early !== 0 || pv_total !== 2)
            $display("FAIL timeout_restart_valid: got %0d/%0d want 0/2 (early/total)", pv_early, pv_total);
        else n_pass++;
        $display("test_timeout done");
    endtask

    task automatic test_saturation();
        int to_n = 0;
        int to_idx = -1;
        int sat_period = 0;
        apply_reset();
        stim = {};
        push_pattern(3, 1, 2);          // rises 0, 3
        push_pattern(255, 1, 1);        // rise 6, next rise 261: gap exactly 255
        push_pattern(256, 1, 1);        // rise 261, next rise 517: times out first
        push_pattern(3, 1, 2);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL sat_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (timeout) begin
                to_n++;
                if (to_idx < 0) to_idx = i;
            end
            if (period_valid && !match && period == CW'(MAXV)) sat_period++;
        end
        n_checks++;
        if (sat_period !== 1) $display("FAIL sat_rise_wins: got %0d saturated periods want 1", sat_period);
        else n_pass++;
        n_checks++;
        if (to_n !== 1 || to_idx !== 261 + MAXV)
            $display("FAIL sat_timeout: got %0d at %0d want 1 at %0d", to_n, to_idx, 261 + MAXV);
        else n_pass++;
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid();
        int lock_rise = 0;
        bit first_pv;
        stim = {};
        push_pattern(3, 1, 6);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rmid_prelock %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
        end
        step(1'b1);
        step(1'b0);
        n_checks++;
        if (locked !== 1'b1) $display("FAIL rmid_locked_before: got %b want 1", locked);
        else n_pass++;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec !== '0) $display("FAIL rmid_async_clear: got %h want 0", obs_vec);
        else n_pass++;
        @(posedge clk);
        #3;
        reset = 1'b1;
        stim = {};
        push_pattern(3, 1, 6);
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rmid_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
            if (i == 0) first_pv = period_valid;
            if (locked && lock_rise == 0) lock_rise = i / 3 + 1;
        end
        n_checks++;
        if (first_pv !== 1'b0) $display("FAIL rmid_first_rise_valid: got %b want 0", first_pv);
        else n_pass++;
        n_checks++;
        if (lock_rise !== 5) $display("FAIL rmid_lock_rise: got %0d want 5", lock_rise);
        else n_pass++;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int per;
        int high;
        stim = {};
        for (int p = 0; p < 120; p++) begin
            per  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 6)) : 3;
            high = $urandom_range(1, per - 1);
            push_pattern(per, high, 1);
            if ($urandom_range(0, 15) == 0)
                for (int k = 0; k < 4; k++) stim.push_back(1'($urandom_range(0, 1)));
        end
        foreach (stim[i]) begin
            step(stim[i]);
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL random_cycle %0d: got %h want %h", i, obs_vec, exp_vec);
            else n_pass++;
        end
        $display("test_random done");
    endtask

    initial begin
        now = 0;
        test_reset();
        test_lock();
        test_lose_lock();
        test_glitch();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_period_monitor.md
DIV_PERIOD_MONITOR -- requirements
Module: div_period_monitor

Interface
REQ-001 Parameter EXP_DIV, default 3, is the expected input period in clk cycles (legal range 2..2^CNT_W-2).
REQ-002 Parameter CNT_W, default 8, is the width of the period counter and of the period output.
REQ-003 Parameter LOCK_CNT, default 4, is the number of consecutive matching periods needed to lock.
REQ-004 Parameter UNLOCK_CNT, default 2, is the number of consecutive mismatching periods that drops lock.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 q_in  input  1  divided pulse train under test, synchronous to clk.
REQ-008 period  output  CNT_W  last measured rise-to-rise period in clk cycles.
REQ-009 period_valid  output  1  one-cycle pulse when period updates.
REQ-010 match  output  1  one-cycle pulse, coincident with period_valid, when period == EXP_DIV.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 lost  output  1  one-cycle pulse on the LOCKED->LOST transition.
REQ-013 timeout  output  1  one-cycle pulse when the counter saturates.

Function
REQ-014 Rise detection: rise = q_in & ~q_prev. q_prev is a register holding q_in from the previous cycle.
REQ-015 Counter cnt: on rise, load 1; otherwise increment, saturating at 2^CNT_W-1.
- A rise N cycles after the previous rise therefore sees cnt == N.
REQ-016 States: IDLE, ACQUIRE, LOCKED, LOST.
REQ-017 IDLE: the first rise moves to ACQUIRE.
- No period is produced; period_valid stays 0.
REQ-018 Outside IDLE, on every rise: period <= cnt and period_valid pulses on the next cycle (latency 1 cycle after the rise cycle).
- match pulses on the same cycle if cnt == EXP_DIV.
REQ-019 ACQUIRE: a match increments match_cnt; a mismatch clears it.
- When match_cnt reaches LOCK_CNT, move to LOCKED and clear match_cnt.
REQ-020 LOCKED: a mismatch increments err_cnt; a match clears it.
- When err_cnt reaches UNLOCK_CNT, move to LOST, pulse lost, and clear err_cnt.
REQ-021 LOST: the next rise is measured normally and the FSM moves to ACQUIRE.
- match_cnt starts at 1 if that rise matched, else 0.
REQ-022 Timeout: if cnt reaches saturation in any state other than IDLE, pulse timeout once and move to IDLE.
- cnt then holds at saturation until the next rise.
REQ-023 Simultaneous saturation and rise: the rise wins. The period is measured as saturation value (a mismatch) and no timeout is raised.
REQ-024 Stuck-high or stuck-low q_in produces no rise and therefore ends in timeout.
REQ-025 locked is a registered decode of state; it falls in the same cycle lost pulses.

Reset
REQ-026 Asserting reset (0) immediately forces state=IDLE, cnt=0, q_prev=0, match_cnt=0, err_cnt=0, period=0, and all outputs to 0.
REQ-027 Reset asserted mid-measurement discards the partial period; after release, the first rise is treated as the IDLE first edge.
REQ-028 Reset release is synchronous to clk as far as operation goes; the first update is on the first rising clk edge after release.

Structure
REQ-029 Package div_mon_pkg SHALL hold the state enum (mon_state_t) and the default constants for EXP_DIV, CNT_W, LOCK_CNT and UNLOCK_CNT.
REQ-030 One sub-module, rise_detect (clk, reset, d, rise), SHALL implement REQ-014.
REQ-031 The FSM and the counters live in div_period_monitor; there are no combinational paths from q_in to any output.

Verification
REQ-032 Drive q_in = 1,0,0 repeating (divide-by-3 waveform) after reset release.
- period_valid pulses every 3 cycles with period=3 and match=1.
- locked rises after the 5th rise (1 IDLE edge + 4 matches).
REQ-033 From LOCKED, insert two periods of 4 cycles.
- match=0 on both, lost pulses once, locked falls.
- Restoring the divide-by-3 pattern relocks after 4 matches.
REQ-034 From LOCKED, insert one period of 2 and then the 3-pattern.
- locked stays 1 and err_cnt clears on the next match.
REQ-035 Hold q_in=0 for 300 cycles from ACQUIRE.
- timeout pulses exactly once about 254 cycles after the last rise; state=IDLE.
- No period_valid until 2 further rises.
REQ-036 Assert reset for 1 cycle mid-period while LOCKED.
- All outputs go to 0 immediately.
- After release, the first rise gives no period_valid; lock needs 5 rises again.
